// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
//   XLEN               datapath width
//   RESET_PC_DEFAULT   PC loaded on reset
//   NOP_INSTR_DEFAULT  bubble instruction (addi x0,x0,0)
//   fetch_state_t      fetch FSM encoding
package fetch_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,
        FS_WAIT  = 2'd1,
        FS_HOLD  = 2'd2,
        FS_DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding fetch at a
// time to instruction memory, buffers the returned word while the hazard
// unit stalls, and applies redirects from EX (discarding stale responses).
//
// Ports
//   clock, reset        single clock, synchronous active-high reset
//   StallF              1 = IF/ID not accepting, hold current instruction
//   PCSrcE, PCTargetE   redirect request and target from EX
//   imem_req_*          request channel (valid/ready, word-aligned address)
//   imem_rsp_*          response channel (single-cycle valid pulse + data)
//   InstrF, PCF,        instruction, its PC and PC+4 towards IF/ID
//   PCPlus4F
//   InstrValidF         InstrF holds a real fetched instruction
//
// state | meaning
// FETCH | request for pc presented, waiting for ready
// WAIT  | request for pc accepted, waiting for response
// HOLD  | buffer holds instruction at pc; prefetch pc+4 when not stalled
// DRAIN | stale request outstanding; drop its response, then fetch pc
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            StallF,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F,
    output logic            InstrValidF
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_buf;

    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_buf_nxt;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_target;
    logic            w_req_valid;
    logic [XLEN-1:0] w_addr;
    logic            w_instr_valid;
    logic [XLEN-1:0] w_instr;

    assign w_pc_plus4 = r_pc + 32'd4;
    // Masking keeps the target word aligned regardless of the low bits EX sends.
    assign w_target   = PCTargetE & ~32'h0000_0003;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_buf_nxt     = r_buf;
        w_req_valid   = 1'b0;
        w_addr        = r_pc;
        w_instr_valid = 1'b0;
        w_instr       = NOP_INSTR;

        case (r_state)
            FS_FETCH: begin
                w_req_valid = 1'b1;
                if (PCSrcE) begin
                    w_pc_nxt    = w_target;
                    w_buf_nxt   = NOP_INSTR;
                    // A request accepted in the redirect cycle is for the old pc.
                    w_state_nxt = imem_req_ready ? FS_DRAIN : FS_FETCH;
                end else if (imem_req_ready) begin
                    w_state_nxt = FS_WAIT;
                end
            end

            FS_WAIT: begin
                if (PCSrcE) begin
                    w_pc_nxt    = w_target;
                    w_buf_nxt   = NOP_INSTR;
                    // Response arriving now is the stale one; nothing left to drain.
                    w_state_nxt = imem_rsp_valid ? FS_FETCH : FS_DRAIN;
                end else if (imem_rsp_valid) begin
                    w_buf_nxt   = imem_rsp_data;
                    w_state_nxt = FS_HOLD;
                end
            end

            FS_HOLD: begin
                w_instr_valid = 1'b1;
                w_instr       = r_buf;
                // Prefetch address stays pc+4 while held so it cannot glitch
                // between a not-ready cycle and the following FETCH.
                w_addr        = w_pc_plus4;
                if (PCSrcE) begin
                    w_pc_nxt    = w_target;
                    w_buf_nxt   = NOP_INSTR;
                    w_state_nxt = FS_FETCH;
                end else if (!StallF) begin
                    w_req_valid = 1'b1;
                    w_pc_nxt    = w_pc_plus4;
                    w_state_nxt = imem_req_ready ? FS_WAIT : FS_FETCH;
                end
            end

            FS_DRAIN: begin
                if (PCSrcE) begin
                    w_pc_nxt  = w_target;
                    w_buf_nxt = NOP_INSTR;
                end
                if (imem_rsp_valid) begin
                    w_state_nxt = FS_FETCH;
                end
            end

            default: begin
                w_state_nxt = FS_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= FS_FETCH;
            r_pc    <= RESET_PC;
            r_buf   <= NOP_INSTR;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_buf   <= w_buf_nxt;
        end
    end

    assign imem_req_valid = w_req_valid & ~reset;
    assign imem_addr      = w_addr;
    assign InstrF         = w_instr;
    assign InstrValidF    = w_instr_valid;
    assign PCF            = r_pc;
    assign PCPlus4F       = w_pc_plus4;

    // Memory must only respond while a request is outstanding.
    a_rsp_only_when_outstanding: assert property (
        @(posedge clock) disable iff (reset)
        !(imem_rsp_valid && (r_state == FS_FETCH || r_state == FS_HOLD))
    );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        InstrValidF;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .StallF         (StallF),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .InstrF         (InstrF),
        .PCF            (PCF),
        .PCPlus4F       (PCPlus4F),
        .InstrValidF    (InstrValidF)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], a[15:0]} ^ 32'h0000_0033;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pop_check();
        exp_t e;
        n_checks++;
        assert (sb_q.size() != 0) else begin
            n_errors++;
            $error("FAIL sb_underflow observed=empty expected=entry");
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("hold_valid", {31'd0, InstrValidF}, 32'd1);
            chk("hold_instr", InstrF, e.instr);
            chk("hold_pcf", PCF, e.pc);
            chk("hold_pcplus4", PCPlus4F, e.pc + 32'd4);
        end
    endtask

    // Issue a request for address a, answer it one cycle later, and check the
    // buffered instruction appears in HOLD.
    task automatic txn(input logic [31:0] a);
        exp_t e;
        chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("req_addr", imem_addr, a);
        imem_req_ready = 1'b1;
        tick();
        chk("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
        chk("wait_invalid", {31'd0, InstrValidF}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(a);
        e.pc    = a;
        e.instr = mem_word(a);
        sb_q.push_back(e);
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        #1;
        pop_check();
    endtask

    initial begin
        reset          = 1'b1;
        StallF         = 1'b0;
        PCSrcE         = 1'b0;
        PCTargetE      = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_valid", {31'd0, InstrValidF}, 32'd0);
        chk("rst_instr", InstrF, 32'h0000_0013);
        chk("rst_pcf", PCF, 32'h0000_0000);
        chk("rst_pcplus4", PCPlus4F, 32'h0000_0004);
        reset = 1'b0;
        #1;

        // Streaming with a 1-cycle memory
        txn(32'h0);
        txn(32'h4);
        txn(32'h8);

        // Stall in HOLD at pc 0x8
        StallF = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
            chk("stall_valid", {31'd0, InstrValidF}, 32'd1);
            chk("stall_pcf", PCF, 32'h8);
            chk("stall_instr", InstrF, mem_word(32'h8));
            tick();
        end
        StallF = 1'b0;
        #1;
        chk("unstall_req", {31'd0, imem_req_valid}, 32'd1);
        chk("unstall_addr", imem_addr, 32'hC);
        txn(32'hC);

        // Redirect while waiting on 0x10; 0x10 response arrives later in DRAIN
        chk("pre_redir_addr", imem_addr, 32'h10);
        tick();
        PCSrcE    = 1'b1;
        PCTargetE = 32'h103;
        #1;
        chk("wait_redir_no_req", {31'd0, imem_req_valid}, 32'd0);
        tick();
        PCSrcE = 1'b0;
        #1;
        chk("drain_pcf", PCF, 32'h100);
        chk("drain_no_req", {31'd0, imem_req_valid}, 32'd0);
        chk("drain_invalid", {31'd0, InstrValidF}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(32'h10);
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        chk("post_drain_invalid", {31'd0, InstrValidF}, 32'd0);
        chk("post_drain_instr", InstrF, 32'h0000_0013);
        txn(32'h100);

        // Redirect coinciding with the response in WAIT
        chk("pre_redir2_addr", imem_addr, 32'h104);
        tick();
        PCSrcE         = 1'b1;
        PCTargetE      = 32'h200;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(32'h104);
        tick();
        PCSrcE         = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        chk("redir_rsp_invalid", {31'd0, InstrValidF}, 32'd0);
        chk("redir_rsp_instr", InstrF, 32'h0000_0013);
        chk("redir_rsp_pcf", PCF, 32'h200);

        // Memory not ready for 4 cycles
        imem_req_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("notready_req", {31'd0, imem_req_valid}, 32'd1);
            chk("notready_addr", imem_addr, 32'h200);
            chk("notready_valid", {31'd0, InstrValidF}, 32'd0);
            chk("notready_instr", InstrF, 32'h0000_0013);
            tick();
        end
        txn(32'h200);

        // Redirect from HOLD to the top of the address space
        PCSrcE    = 1'b1;
        PCTargetE = 32'hFFFF_FFFE;
        #1;
        chk("hold_redir_no_req", {31'd0, imem_req_valid}, 32'd0);
        tick();
        PCSrcE = 1'b0;
        #1;
        chk("wrap_pcf", PCF, 32'hFFFF_FFFC);
        chk("wrap_pcplus4", PCPlus4F, 32'h0000_0000);
        chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_invalid", {31'd0, InstrValidF}, 32'd0);

        // Reset while the request is outstanding; its response arrives late
        imem_req_ready = 1'b1;
        tick();
        chk("wrap_wait_no_req", {31'd0, imem_req_valid}, 32'd0);
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        tick();
        chk("midrst_pcf", PCF, 32'h0);
        chk("midrst_no_req", {31'd0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(32'hFFFF_FFFC);
        tick();
        imem_rsp_valid = 1'b0;
        reset          = 1'b0;
        #1;
        chk("late_rsp_invalid", {31'd0, InstrValidF}, 32'd0);
        chk("late_rsp_instr", InstrF, 32'h0000_0013);
        chk("late_rsp_req", {31'd0, imem_req_valid}, 32'd1);
        chk("late_rsp_addr", imem_addr, 32'h0);

        // Redirect from FETCH in the handshake cycle: accepted request is stale
        imem_req_ready = 1'b1;
        PCSrcE         = 1'b1;
        PCTargetE      = 32'h300;
        #1;
        chk("fetch_redir_req", {31'd0, imem_req_valid}, 32'd1);
        tick();
        PCSrcE = 1'b0;
        #1;
        chk("fetch_redir_pcf", PCF, 32'h300);
        chk("fetch_redir_drain", {31'd0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(32'h0);
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        chk("fetch_redir_invalid", {31'd0, InstrValidF}, 32'd0);
        txn(32'h300);

        chk("sb_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
